// File: rtl/bcd_display_scanner.sv
// Three-digit multiplexed 7-segment scanner for a BCD decade counter.
// Frame-coherent snapshot, leading-zero blanking, sticky overflow on hundreds dp.
module bcd_display_scanner #(
   parameter int REFRESH_DIV    = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] ones,
   input  logic [3:0] tens,
   input  logic [3:0] hundreds,
   input  logic       ovf_in,
   input  logic       clr_ovf,
   input  logic       blank_en,
   output logic [6:0] seg,
   output logic       dp,
   output logic [2:0] an,
   output logic       ovf_flag
);

   localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

   localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
   localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [2:0] AN_OFF  = {3{AN_ACTIVE_LOW}};

   typedef enum logic [1:0] {
      S_ONES = 2'd0,
      S_TENS = 2'd1,
      S_HUND = 2'd2
   } slot_e;

   logic [CW-1:0] cnt_q, cnt_d;
   slot_e         slot_q, slot_d;
   logic          started_q, started_d;
   logic [3:0]    o_q, o_d, t_q, t_d, h_q, h_d;
   logic          bl_q, bl_d;
   logic          ovf_q, ovf_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [2:0]    an_q, an_d;

   logic          tick;
   logic          tens_blank, hund_blank;
   logic [6:0]    seg_ah;
   logic          dp_ah;
   logic [2:0]    an_ah;

   function automatic logic [6:0] dec7(input logic [3:0] d);
      case (d)
         4'd0:    dec7 = 7'h3F;
         4'd1:    dec7 = 7'h06;
         4'd2:    dec7 = 7'h5B;
         4'd3:    dec7 = 7'h4F;
         4'd4:    dec7 = 7'h66;
         4'd5:    dec7 = 7'h6D;
         4'd6:    dec7 = 7'h7D;
         4'd7:    dec7 = 7'h07;
         4'd8:    dec7 = 7'h7F;
         4'd9:    dec7 = 7'h6F;
         default: dec7 = 7'h40;
      endcase
   endfunction

   always_comb begin
      tick      = (cnt_q == LAST);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      started_d = started_q | tick;

      // First tick after reset lands on ones instead of advancing past it
      slot_d = slot_q;
      if (tick) begin
         if (!started_q) begin
            slot_d = S_ONES;
         end else begin
            case (slot_q)
               S_ONES:  slot_d = S_TENS;
               S_TENS:  slot_d = S_HUND;
               default: slot_d = S_ONES;
            endcase
         end
      end

      o_d  = o_q;
      t_d  = t_q;
      h_d  = h_q;
      bl_d = bl_q;
      if (tick && slot_d == S_ONES) begin
         o_d  = ones;
         t_d  = tens;
         h_d  = hundreds;
         bl_d = blank_en;
      end

      ovf_d = ovf_in ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);

      hund_blank = bl_d && (h_d == 4'd0);
      tens_blank = hund_blank && (t_d == 4'd0);

      seg_ah = 7'h00;
      dp_ah  = 1'b0;
      an_ah  = 3'b000;
      if (started_d) begin
         case (slot_d)
            S_ONES: begin
               an_ah  = 3'b001;
               seg_ah = dec7(o_d);
            end
            S_TENS: begin
               if (!tens_blank) begin
                  an_ah  = 3'b010;
                  seg_ah = dec7(t_d);
               end
            end
            default: begin
               if (!hund_blank) begin
                  an_ah  = 3'b100;
                  seg_ah = dec7(h_d);
               end
               if (ovf_d) begin
                  an_ah = 3'b100;
                  dp_ah = 1'b1;
               end
            end
         endcase
      end

      seg_d = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_ah : dp_ah;
      an_d  = AN_ACTIVE_LOW ? ~an_ah : an_ah;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         slot_q    <= S_ONES;
         started_q <= 1'b0;
         o_q       <= 4'd0;
         t_q       <= 4'd0;
         h_q       <= 4'd0;
         bl_q      <= 1'b0;
         ovf_q     <= 1'b0;
         seg_q     <= SEG_OFF;
         dp_q      <= DP_OFF;
         an_q      <= AN_OFF;
      end else begin
         cnt_q     <= cnt_d;
         slot_q    <= slot_d;
         started_q <= started_d;
         o_q       <= o_d;
         t_q       <= t_d;
         h_q       <= h_d;
         bl_q      <= bl_d;
         ovf_q     <= ovf_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign seg      = seg_q;
   assign dp       = dp_q;
   assign an       = an_q;
   assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at REFRESH_DIV=4, active-low outputs.
// Frame starts after release land on cycles 5, 17, 29, ... (12-cycle frames).
module tb_bcd_display_scanner;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] ones = 4'd1, tens = 4'd2, hundreds = 4'd3;
   logic       ovf_in = 1'b0, clr_ovf = 1'b0, blank_en = 1'b0;
   logic [6:0] seg;
   logic       dp;
   logic [2:0] an;
   logic       ovf_flag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bcd_display_scanner #(
      .REFRESH_DIV(4),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ones(ones),
      .tens(tens),
      .hundreds(hundreds),
      .ovf_in(ovf_in),
      .clr_ovf(clr_ovf),
      .blank_en(blank_en),
      .seg(seg),
      .dp(dp),
      .an(an),
      .ovf_flag(ovf_flag)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic look(input string tag, input logic [2:0] e_an,
                       input logic [6:0] e_seg, input logic e_dp);
      chk({tag, ".an"}, {5'd0, an}, {5'd0, e_an});
      chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
      chk({tag, ".dp"}, {7'd0, dp}, {7'd0, e_dp});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      look("c1", 3'b111, 7'h7F, 1'b1);
      chk("c1.ovf", {7'd0, ovf_flag}, 8'd0);
      cyc(3); look("c4", 3'b111, 7'h7F, 1'b1);
      cyc(1); look("c5", 3'b110, 7'h79, 1'b1);
      cyc(4); look("c9", 3'b101, 7'h24, 1'b1);
      cyc(4); look("c13", 3'b011, 7'h30, 1'b1);
      cyc(4); look("c17", 3'b110, 7'h79, 1'b1);

      ones = 4'd5; tens = 4'd0; hundreds = 4'd0; blank_en = 1'b1;
      cyc(12); look("b500.o", 3'b110, 7'h12, 1'b1);
      cyc(4);  look("b500.t", 3'b111, 7'h7F, 1'b1);
      cyc(4);  look("b500.h", 3'b111, 7'h7F, 1'b1);

      ones = 4'd0;
      cyc(4); look("b000.o", 3'b110, 7'h40, 1'b1);
      cyc(4); look("b000.t", 3'b111, 7'h7F, 1'b1);
      cyc(4); look("b000.h", 3'b111, 7'h7F, 1'b1);
      blank_en = 1'b0;
      cyc(4); look("n000.o", 3'b110, 7'h40, 1'b1);
      cyc(4); look("n000.t", 3'b101, 7'h40, 1'b1);
      cyc(4); look("n000.h", 3'b011, 7'h40, 1'b1);

      ones = 4'd7; tens = 4'd1; hundreds = 4'd0;
      cyc(4); look("torn.o7", 3'b110, 7'h78, 1'b1);
      cyc(4);
      ones = 4'd8;
      look("torn.t", 3'b101, 7'h79, 1'b1);
      cyc(4); look("torn.h", 3'b011, 7'h40, 1'b1);
      cyc(4); look("torn.o8", 3'b110, 7'h00, 1'b1);
      ones = 4'd9;
      cyc(1); look("torn.hold", 3'b110, 7'h00, 1'b1);

      ones = 4'd1; tens = 4'hC; hundreds = 4'd0; blank_en = 1'b1;
      cyc(11); look("inv.o", 3'b110, 7'h79, 1'b1);
      cyc(4);  look("inv.t", 3'b101, 7'h3F, 1'b1);
      cyc(4);  look("inv.h", 3'b111, 7'h7F, 1'b1);

      ovf_in = 1'b1;
      cyc(1);
      ovf_in = 1'b0;
      chk("ovf.set", {7'd0, ovf_flag}, 8'd1);
      look("ovf.h", 3'b011, 7'h7F, 1'b0);
      cyc(3); look("ovf.o", 3'b110, 7'h79, 1'b1);
      ovf_in = 1'b1; clr_ovf = 1'b1;
      cyc(1);
      ovf_in = 1'b0; clr_ovf = 1'b0;
      chk("ovf.both", {7'd0, ovf_flag}, 8'd1);
      cyc(7); look("ovf.h2", 3'b011, 7'h7F, 1'b0);
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      chk("ovf.clr", {7'd0, ovf_flag}, 8'd0);
      look("ovf.h3", 3'b111, 7'h7F, 1'b1);

      ovf_in = 1'b1;
      cyc(1);
      ovf_in = 1'b0;
      chk("rst.pre", {7'd0, ovf_flag}, 8'd1);
      reset = 1'b1;
      cyc(1);
      look("rst.mid", 3'b111, 7'h7F, 1'b1);
      chk("rst.ovf", {7'd0, ovf_flag}, 8'd0);
      reset = 1'b0;
      cyc(3); look("rst.c4", 3'b111, 7'h7F, 1'b1);
      cyc(1); look("rst.c5", 3'b110, 7'h79, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
